// File: rtl/program_loader_if.sv
`default_nettype none
// ============================================================================
// Module  : program_loader_if
// Brief   : Byte-stream input and program-memory write port of the loader.
// Revision: 1.0
// ============================================================================
interface program_loader_if #(
    parameter int ADDR_WIDTH = 5
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [31:0]           mem_data;
    logic                  mem_wren;
    logic                  cpu_hold;
    logic                  load_done;
    logic                  load_error;
    logic [ADDR_WIDTH:0]   words_loaded;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready, mem_address, mem_data, mem_wren,
        output cpu_hold, load_done, load_error, words_loaded
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, mem_address, mem_data, mem_wren,
        input  cpu_hold, load_done, load_error, words_loaded
    );
endinterface
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module  : program_loader
// Brief   : Frames a byte stream into 32-bit words and writes program memory
//           while holding the core in reset.
// Revision: 1.0
// ============================================================================
module program_loader #(
    parameter int ADDR_WIDTH     = 5,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    program_loader_if.master bus
);
    localparam int LW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] c_TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WRITE = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    state_t                r_state;
    logic [LW-1:0]         r_len;
    logic [LW-1:0]         r_words;
    logic [1:0]            r_idx;
    logic [23:0]           r_word;
    logic [7:0]            r_csum;
    logic [TW-1:0]         r_timer;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [31:0]           r_mem_data;
    logic                  r_mem_wren;
    logic                  r_cpu_hold;
    logic                  r_done;
    logic                  r_err;

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_len_ok;
    logic [LW-1:0]         w_words_inc;
    logic [7:0]            w_csum_next;

    // The only cycle a byte cannot be taken is the single memory write cycle.
    assign w_ready     = (r_state != S_WRITE);
    assign w_accept    = bus.rx_valid && w_ready;
    assign w_len_ok    = (bus.rx_data != 8'd0) && (32'(bus.rx_data) <= 32'(DEPTH));
    assign w_words_inc = r_words + LW'(1);
    assign w_csum_next = r_csum + bus.rx_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_words    <= '0;
            r_idx      <= 2'd0;
            r_word     <= 24'd0;
            r_csum     <= 8'd0;
            r_timer    <= '0;
            r_mem_addr <= '0;
            r_mem_data <= 32'd0;
            r_mem_wren <= 1'b0;
            r_cpu_hold <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_mem_wren <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (w_accept) begin
                        r_cpu_hold <= 1'b1;
                        r_done     <= 1'b0;
                        r_words    <= '0;
                        if (w_len_ok) begin
                            r_state <= S_LOAD;
                            r_err   <= 1'b0;
                            r_len   <= LW'(bus.rx_data);
                            r_idx   <= 2'd0;
                            r_csum  <= 8'd0;
                            r_timer <= '0;
                        end else begin
                            r_state <= S_ERROR;
                            r_err   <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_timer <= '0;
                        r_csum  <= w_csum_next;
                        r_idx   <= r_idx + 2'd1;
                        case (r_idx)
                            2'd0: r_word[7:0]   <= bus.rx_data;
                            2'd1: r_word[15:8]  <= bus.rx_data;
                            2'd2: r_word[23:16] <= bus.rx_data;
                            default: begin
                                r_state    <= S_WRITE;
                                r_mem_wren <= 1'b1;
                                r_mem_addr <= r_words[ADDR_WIDTH-1:0];
                                r_mem_data <= {bus.rx_data, r_word};
                            end
                        endcase
                    end else if (r_timer == c_TIMER_LAST) begin
                        r_state <= S_ERROR;
                        r_err   <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_WRITE: begin
                    r_words <= w_words_inc;
                    r_timer <= '0;
                    r_state <= (w_words_inc == r_len) ? S_CHECK : S_LOAD;
                end
                S_CHECK: begin
                    if (w_accept) begin
                        if (bus.rx_data == r_csum) begin
                            r_state    <= S_DONE;
                            r_cpu_hold <= 1'b0;
                            r_done     <= 1'b1;
                        end else begin
                            r_state <= S_ERROR;
                            r_err   <= 1'b1;
                        end
                    end else if (r_timer == c_TIMER_LAST) begin
                        r_state <= S_ERROR;
                        r_err   <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.rx_ready     = w_ready;
    assign bus.mem_address  = r_mem_addr;
    assign bus.mem_data     = r_mem_data;
    assign bus.mem_wren     = r_mem_wren;
    assign bus.cpu_hold     = r_cpu_hold;
    assign bus.load_done    = r_done;
    assign bus.load_error   = r_err;
    assign bus.words_loaded = r_words;
endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_program_loader
// Brief   : Randomized self-checking bench for program_loader.
// Revision: 1.0
// ============================================================================
module tb_program_loader;
    localparam int AW = 5;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    program_loader_if #(.ADDR_WIDTH(AW)) bus ();
    program_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW-1:0] cap_addr[$];
    logic [31:0]   cap_data[$];
    int            rdy_low = 0;
    int            inv_bad = 0;
    logic [7:0]    fb[$];

    // Write log plus the rule that rx_ready is low exactly while a write is in flight.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_wren === 1'b1) begin
                cap_addr.push_back(bus.mem_address);
                cap_data.push_back(bus.mem_data);
            end
            if (bus.rx_ready === 1'b0) rdy_low++;
            if (bus.rx_ready !== !bus.mem_wren) inv_bad++;
        end
    end

    task automatic clear_log();
        cap_addr.delete();
        cap_data.delete();
        rdy_low = 0;
        inv_bad = 0;
    endtask

    task automatic idle(input int k);
        bus.rx_valid = 1'b0;
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (bus.rx_ready !== 1'b1 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 50) begin
            n_checks++; n_fail++;
            $display("FAIL send_byte_wait: rx_ready=%b, required 1 within 50 cycles", bus.rx_ready);
        end else begin
            @(posedge clk); #1;
        end
    endtask

    task automatic fill_random(input int n);
        fb.delete();
        for (int i = 0; i < 4 * n; i++) fb.push_back(8'($urandom));
    endtask

    // Sends length, fb[] and a checksum (corrupted by +1 when asked), then checks the result.
    task automatic run_frame(input string name, input bit corrupt, input int max_gap);
        int n;
        logic [7:0] sum;
        logic [31:0] exp_w;
        n   = fb.size() / 4;
        sum = 8'd0;
        foreach (fb[i]) sum = sum + fb[i];
        if (corrupt) sum = sum + 8'd1;
        clear_log();
        send_byte(8'(n));
        n_checks++;
        if (bus.cpu_hold !== 1'b1) begin
            n_fail++; $display("FAIL %s hold_after_len: cpu_hold=%b required 1", name, bus.cpu_hold);
        end
        foreach (fb[i]) begin
            if (max_gap > 0) idle($urandom_range(0, max_gap));
            send_byte(fb[i]);
        end
        if (max_gap > 0) idle($urandom_range(0, max_gap));
        send_byte(sum);
        bus.rx_valid = 1'b0;
        n_checks++;
        if (bus.load_done !== !corrupt || bus.load_error !== corrupt || bus.cpu_hold !== corrupt) begin
            n_fail++;
            $display("FAIL %s status: done/err/hold=%b%b%b required %b%b%b", name,
                     bus.load_done, bus.load_error, bus.cpu_hold, !corrupt, corrupt, corrupt);
        end
        n_checks++;
        if (bus.words_loaded !== (AW+1)'(n)) begin
            n_fail++; $display("FAIL %s words_loaded: got %0d required %0d", name, bus.words_loaded, n);
        end
        n_checks++;
        if (cap_addr.size() != n) begin
            n_fail++; $display("FAIL %s write_count: got %0d required %0d", name, cap_addr.size(), n);
        end
        for (int w = 0; w < n && w < cap_addr.size(); w++) begin
            exp_w = {fb[4*w+3], fb[4*w+2], fb[4*w+1], fb[4*w]};
            n_checks++;
            if (cap_addr[w] !== AW'(w) || cap_data[w] !== exp_w) begin
                n_fail++;
                $display("FAIL %s write[%0d]: got %h@%0d required %h@%0d", name, w,
                         cap_data[w], cap_addr[w], exp_w, w);
            end
        end
        n_checks++;
        if (rdy_low != n || inv_bad != 0) begin
            n_fail++;
            $display("FAIL %s ready_gaps: low_cycles=%0d bad=%0d required %0d and 0", name, rdy_low, inv_bad, n);
        end
    endtask

    task automatic check_reset_values(input string name);
        n_checks++;
        if ({bus.mem_wren, bus.mem_address, bus.mem_data, bus.cpu_hold,
             bus.load_done, bus.load_error, bus.words_loaded} !== '0) begin
            n_fail++;
            $display("FAIL %s outputs: wren=%b addr=%0d data=%h hold=%b done=%b err=%b words=%0d required all 0",
                     name, bus.mem_wren, bus.mem_address, bus.mem_data, bus.cpu_hold,
                     bus.load_done, bus.load_error, bus.words_loaded);
        end
        n_checks++;
        if (bus.rx_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s rx_ready: got %b required 1", name, bus.rx_ready);
        end
    endtask

    task automatic test_reset();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'd0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_values("after_reset");
    endtask

    task automatic test_good_frame();
        fb = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_frame("good_frame", 1'b0, 0);
    endtask

    task automatic test_bad_checksum();
        fb = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_frame("bad_checksum", 1'b1, 0);
    endtask

    task automatic test_bad_length();
        logic [7:0] lens[2];
        lens[0] = 8'h00;
        lens[1] = 8'h21;
        clear_log();
        foreach (lens[i]) begin
            send_byte(lens[i]);
            bus.rx_valid = 1'b0;
            n_checks++;
            if (bus.load_error !== 1'b1 || bus.cpu_hold !== 1'b1 || bus.load_done !== 1'b0) begin
                n_fail++;
                $display("FAIL bad_length_%h: err/hold/done=%b%b%b required 110", lens[i],
                         bus.load_error, bus.cpu_hold, bus.load_done);
            end
            idle(3);
        end
        n_checks++;
        if (cap_addr.size() != 0) begin
            n_fail++; $display("FAIL bad_length_writes: got %0d required 0", cap_addr.size());
        end
        fill_random(1);
        run_frame("after_bad_length", 1'b0, 2);
    endtask

    task automatic test_back_to_back();
        fill_random(32);
        run_frame("back_to_back", 1'b0, 0);
    endtask

    task automatic test_random_frames();
        for (int k = 0; k < 6; k++) begin
            fill_random($urandom_range(1, 32));
            run_frame("random_frame", ($urandom_range(0, 3) == 0), 6);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] sum;
        logic [31:0] exp_w;
        fill_random(1);
        send_byte(8'd1);
        send_byte(fb[0]);
        send_byte(fb[1]);
        idle(TO);
        n_checks++;
        if (bus.load_error !== 1'b1 || bus.cpu_hold !== 1'b1 || bus.load_done !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_expired: err/hold/done=%b%b%b required 110",
                     bus.load_error, bus.cpu_hold, bus.load_done);
        end
        fill_random(1);
        sum = fb[0] + fb[1] + fb[2] + fb[3];
        exp_w = {fb[3], fb[2], fb[1], fb[0]};
        clear_log();
        send_byte(8'd1);
        send_byte(fb[0]);
        send_byte(fb[1]);
        idle(TO - 1);
        n_checks++;
        if (bus.load_error !== 1'b0) begin
            n_fail++; $display("FAIL timeout_early: load_error=%b required 0", bus.load_error);
        end
        send_byte(fb[2]);
        send_byte(fb[3]);
        send_byte(sum);
        bus.rx_valid = 1'b0;
        n_checks++;
        if (bus.load_done !== 1'b1 || bus.load_error !== 1'b0 || bus.cpu_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_resume: done/err/hold=%b%b%b required 100",
                     bus.load_done, bus.load_error, bus.cpu_hold);
        end
        n_checks++;
        if (cap_data.size() != 1 || cap_data[0] !== exp_w) begin
            n_fail++;
            $display("FAIL timeout_resume_write: count=%0d data=%h required 1 and %h",
                     cap_data.size(), (cap_data.size() > 0) ? cap_data[0] : 32'hx, exp_w);
        end
    endtask

    task automatic test_reset_mid();
        clear_log();
        send_byte(8'd3);
        send_byte(8'hA5);
        send_byte(8'h5A);
        bus.rx_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("reset_mid");
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_checks++;
        if (cap_addr.size() != 0) begin
            n_fail++; $display("FAIL reset_mid_writes: got %0d required 0", cap_addr.size());
        end
        fill_random(3);
        run_frame("after_reset_mid", 1'b0, 3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_bad_length();
        test_back_to_back();
        test_random_frames();
        test_timeout();
        test_reset_mid();
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/program_loader.md
# program_loader

Serial program-image writer for the instruction memory the fetch unit reads. Accepts a byte stream (from the UART receiver) with a valid/ready handshake, assembles little-endian 32-bit instruction words, and drives the write port of the program memory (address, data, wren) while holding the core in reset. It is the write side of the program memory: the fetch unit reads words by index `pc >> 2`; this block fills the same indices.

## Interface
Parameters:
- ADDR_WIDTH, 5, word-address width of program memory (depth = 2^ADDR_WIDTH words)
- TIMEOUT_CYCLES, 1000000, max idle cycles between accepted bytes inside a frame

Ports:
- clk  input  1  system clock; all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- rx_data  input  8  incoming byte
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  loader can accept a byte this cycle
- mem_address  output  ADDR_WIDTH  program memory word address
- mem_data  output  32  instruction word to write
- mem_wren  output  1  one-cycle write strobe
- cpu_hold  output  1  holds core (PC/pipeline) in reset while high
- load_done  output  1  last frame loaded and checksum matched
- load_error  output  1  last frame failed (bad length, checksum, timeout)
- words_loaded  output  ADDR_WIDTH+1  words written in current/last frame

## Operation
- Frame: 1 length byte N (words), then 4·N data bytes (byte 0 = bits 7:0 of word 0), then 1 checksum byte = sum of all data bytes mod 256 (length byte excluded).
- Byte accepted when rx_valid && rx_ready; nothing else consumes a byte.
- States: IDLE, LOAD, WRITE, CHECK, DONE, ERROR.
- IDLE/DONE/ERROR: rx_ready=1. Accepted byte is length N. If 1 ≤ N ≤ 2^ADDR_WIDTH -> LOAD, cpu_hold=1, load_done=0, load_error=0, words_loaded=0, byte index=0, checksum=0. Else (N=0 or N>depth) -> ERROR, cpu_hold=1.
- LOAD: rx_ready=1. Each byte shifts into byte lane [index], added to checksum (8-bit wrap). On 4th byte -> WRITE.
- WRITE (exactly 1 cycle): rx_ready=0, mem_wren=1, mem_address=words_loaded[ADDR_WIDTH-1:0], mem_data=assembled word. Next cycle words_loaded+1; if new count = N -> CHECK else LOAD.
- CHECK: rx_ready=1. Accepted byte equal to checksum -> DONE (cpu_hold=0, load_done=1); else -> ERROR (load_error=1, cpu_hold stays 1).
- Timeout: in LOAD and CHECK, idle counter clears on each accepted byte and on state entry; when it reaches TIMEOUT_CYCLES -> ERROR. Counter frozen in other states.
- Memory words already written are not rolled back on error; ERROR only keeps the core held.
- mem_data/mem_address hold their last values when mem_wren=0.
- N = 2^ADDR_WIDTH: last write to address depth-1; words_loaded reaches depth with no wrap (hence ADDR_WIDTH+1 bits).

## Timing
- Reset (async, rst_n low): state IDLE, rx_ready=1 after release, mem_wren=0, mem_address=0, mem_data=0, cpu_hold=0 (preloaded image boots), load_done=0, load_error=0, words_loaded=0, counters 0.
- All outputs registered except rx_ready (decoded from state).
- Length byte accepted at edge t -> cpu_hold=1 from t+1.
- 4th byte of a word accepted at edge t -> mem_wren=1 in cycle t..t+1 (sampled by memory at edge t+1); rx_ready=0 in that cycle; next byte accepted no earlier than edge t+2.
- Max throughput: 4 bytes per 5 cycles.
- Checksum accepted at edge t -> load_done or load_error and cpu_hold update at t+1.
- rst_n asserted mid-frame: immediate return to reset values; a partially written image is abandoned, cpu_hold drops to 0.

## Test plan
- N=2, bytes 13 00 00 00 93 00 10 00, checksum 0xB6 -> writes 0x00000013 @0, 0x00100093 @1, one mem_wren per word, load_done=1, cpu_hold=0, words_loaded=2.
- Same frame, checksum 0xB7 -> both words written, load_error=1, cpu_hold=1, load_done=0.
- Length 0x00 then 0x21 (ADDR_WIDTH=5) -> ERROR with no mem_wren; then a valid N=1 frame -> load_done=1.
- N=32, random data, rx_valid held high -> 32 writes to addresses 0..31, rx_ready low exactly in each WRITE cycle, words_loaded=32, correct checksum -> done.
- TIMEOUT_CYCLES=16, send length 1 and two data bytes, then stall 16 cycles -> load_error=1; stall of 15 cycles then resume -> no error.
- Assert rst_n mid-word after length and 2 data bytes -> all outputs at reset values, no mem_wren, next frame loads cleanly.
